led_switch_io: RTL and testbench

- Memory-mapped LED/switch peripheral directly downstream of the CPU's memory/IO steering stage.
- Consumes that stage's LED chip select, switch chip select, low address bits and 16-bit write data.
- Returns 16-bit switch read data.
- Holds the 24 board LEDs in registers; synchronises and debounces the 24 board switches; keeps a sticky "switches changed" flag that software can poll.

---
 rtl/io_pkg.sv | 39 +++
 rtl/switch_debounce.sv | 78 +++++++
 rtl/led_switch_io.sv | 96 +++++++++
 tb/tb_led_switch_io.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// ---------------------------------------------------------------------------
// io_pkg
// Shared constants for the memory-mapped LED/switch peripheral and the
// steering stage that selects it.
//   IO_BASE_ADDR   : base address of the IO window decoded by the steering stage
//   IO_OFF_*       : byte offsets within the window (addr_out[2:0])
//   LED_W / SW_W   : number of board LEDs / switches
//   io_sel_e       : decoded register selection for an IO offset
// ---------------------------------------------------------------------------
package io_pkg;

  localparam logic [31:0] IO_BASE_ADDR = 32'hFFFF_FC00;

  localparam logic [2:0] IO_OFF_SW_LO  = 3'h0;
  localparam logic [2:0] IO_OFF_SW_HI  = 3'h2;
  localparam logic [2:0] IO_OFF_STATUS = 3'h4;

  localparam int LED_W = 24;
  localparam int SW_W  = 24;

  typedef enum logic [1:0] {
    SEL_LO     = 2'd0,
    SEL_HI     = 2'd1,
    SEL_STATUS = 2'd2,
    SEL_NONE   = 2'd3
  } io_sel_e;

  // Map a byte offset onto the register it addresses; unmapped offsets
  // select nothing so writes are dropped and reads return zero.
  function automatic io_sel_e decode_off(input logic [2:0] off);
    case (off)
      IO_OFF_SW_LO:  return SEL_LO;
      IO_OFF_SW_HI:  return SEL_HI;
      IO_OFF_STATUS: return SEL_STATUS;
      default:       return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// ---------------------------------------------------------------------------
// switch_debounce
// Two-flop synchroniser plus whole-vector debouncer for the board switches.
// A new switch vector is committed to 'stable' only after it has been seen
// unchanged for DEBOUNCE_CYCLES consecutive clocks; any difference restarts
// the count.
//   clock, reset   : system clock, asynchronous active-high reset
//   raw            : raw switches, asynchronous to clock
//   stable         : debounced switch vector
//   changed_pulse  : high for the one cycle whose closing edge loads a
//                    different value into 'stable'
// ---------------------------------------------------------------------------
module switch_debounce
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [SW_W-1:0] raw,
  output logic [SW_W-1:0] stable,
  output logic            changed_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_W-1:0]  sync1_q,  sync1_d;
  logic [SW_W-1:0]  sync2_q,  sync2_d;
  logic [SW_W-1:0]  cand_q,   cand_d;
  logic [SW_W-1:0]  stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    cand_d   = cand_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;

    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_MAX) begin
      // Counter saturates here; reloading an identical value each cycle is
      // harmless and keeps 'stable' tracking the candidate.
      stable_d = cand_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Combinational so the sticky flag in the parent sets on the same edge
  // that updates 'stable'.
  assign changed_pulse = (stable_d != stable_q);
  assign stable        = stable_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/led_switch_io.sv
// ---------------------------------------------------------------------------
// led_switch_io
// Memory-mapped LED/switch peripheral behind the CPU's memory/IO steering
// stage. Offsets: 0x0 switches[15:0] / LEDs[15:0], 0x2 switches[23:16] /
// LEDs[23:16], 0x4 status (bit 0 = switches-changed, cleared on read).
//   clock, reset : system clock, asynchronous active-high reset
//   led_cs       : LED write select (write on rising edge)
//   switch_cs    : switch read select (combinational read data)
//   io_addr      : byte offset within the IO window
//   io_wdata     : write data
//   sw_raw       : raw board switches (asynchronous)
//   io_rdata     : read data, zero when switch_cs is low
//   led_out      : board LED drive
// ---------------------------------------------------------------------------
module led_switch_io
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             led_cs,
  input  logic             switch_cs,
  input  logic [2:0]       io_addr,
  input  logic [15:0]      io_wdata,
  input  logic [SW_W-1:0]  sw_raw,
  output logic [15:0]      io_rdata,
  output logic [LED_W-1:0] led_out
);

  logic [LED_W-1:0] led_q, led_d;
  logic             flag_q, flag_d;
  logic [SW_W-1:0]  sw_stable;
  logic             sw_changed;
  io_sel_e          sel;

  switch_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clock         (clock),
    .reset         (reset),
    .raw           (sw_raw),
    .stable        (sw_stable),
    .changed_pulse (sw_changed)
  );

  assign sel = decode_off(io_addr);

  always_comb begin
    led_d = led_q;
    if (led_cs) begin
      case (sel)
        SEL_LO:  led_d[15:0]  = io_wdata;
        SEL_HI:  led_d[23:16] = io_wdata[7:0];
        default: ;
      endcase
    end
  end

  // Set has priority over the read-clear so a change landing on the same
  // edge as a status read is not lost.
  always_comb begin
    flag_d = flag_q;
    if (switch_cs && sel == SEL_STATUS) flag_d = 1'b0;
    if (sw_changed)                     flag_d = 1'b1;
  end

  always_comb begin
    io_rdata = 16'h0000;
    if (switch_cs) begin
      case (sel)
        SEL_LO:     io_rdata = sw_stable[15:0];
        SEL_HI:     io_rdata = {8'h00, sw_stable[23:16]};
        SEL_STATUS: io_rdata = {15'h0000, flag_q};
        default:    io_rdata = 16'h0000;
      endcase
    end
  end

  // NOTE: reset is asynchronous, so LEDs and the flag clear as soon as reset
  // rises, without waiting for a clock edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      led_q  <= led_d;
      flag_q <= flag_d;
    end
  end

  assign led_out = led_q;

endmodule

// File: tb/tb_led_switch_io.sv
// ---------------------------------------------------------------------------
// tb_led_switch_io
// Directed, table-driven bench for led_switch_io with DEBOUNCE_CYCLES=4, so a
// clean switch change reaches the stable register 7 clocks after it is
// applied.
// ---------------------------------------------------------------------------
module tb_led_switch_io;
  import io_pkg::*;

  localparam int DEB = 4;

  logic             clock;
  logic             reset;
  logic             led_cs;
  logic             switch_cs;
  logic [2:0]       io_addr;
  logic [15:0]      io_wdata;
  logic [SW_W-1:0]  sw_raw;
  logic [15:0]      io_rdata;
  logic [LED_W-1:0] led_out;

  int n_total = 0;
  int n_pass  = 0;

  led_switch_io #(
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .led_cs    (led_cs),
    .switch_cs (switch_cs),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .sw_raw    (sw_raw),
    .io_rdata  (io_rdata),
    .led_out   (led_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        led_cs;
    logic        switch_cs;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic [23:0] exp_led;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Single read that does not span a clock edge, so it never clears the flag.
  task automatic check_rd(input string name, input logic [2:0] a, input logic [15:0] exp);
    switch_cs = 1'b1;
    io_addr   = a;
    #1;
    check(name, {16'h0, io_rdata}, {16'h0, exp});
    switch_cs = 1'b0;
  endtask

  vec_t vecs[11];

  initial begin
    // Writes then reads, starting from stable=FFFFFF and flag=1.
    vecs[0]  = '{1'b1, 1'b0, 3'h0, 16'hA5C3, 16'h0000, 24'h00A5C3};
    vecs[1]  = '{1'b1, 1'b0, 3'h2, 16'h12FE, 16'h0000, 24'hFEA5C3};
    vecs[2]  = '{1'b1, 1'b0, 3'h6, 16'hFFFF, 16'h0000, 24'hFEA5C3};
    vecs[3]  = '{1'b1, 1'b0, 3'h4, 16'hFFFF, 16'h0000, 24'hFEA5C3};
    vecs[4]  = '{1'b0, 1'b0, 3'h0, 16'h0000, 16'h0000, 24'hFEA5C3};
    vecs[5]  = '{1'b0, 1'b1, 3'h0, 16'h0000, 16'hFFFF, 24'hFEA5C3};
    vecs[6]  = '{1'b0, 1'b1, 3'h2, 16'h0000, 16'h00FF, 24'hFEA5C3};
    vecs[7]  = '{1'b0, 1'b1, 3'h6, 16'h0000, 16'h0000, 24'hFEA5C3};
    vecs[8]  = '{1'b0, 1'b1, 3'h4, 16'h0000, 16'h0001, 24'hFEA5C3};
    vecs[9]  = '{1'b0, 1'b1, 3'h4, 16'h0000, 16'h0000, 24'hFEA5C3};
    vecs[10] = '{1'b1, 1'b1, 3'h0, 16'h0011, 16'hFFFF, 24'hFE0011};

    reset     = 1'b1;
    led_cs    = 1'b0;
    switch_cs = 1'b0;
    io_addr   = 3'h0;
    io_wdata  = 16'h0;
    sw_raw    = 24'hFFFFFF;

    // ---- reset state ----
    step(3);
    check("rst_led", {8'h0, led_out}, 32'h0);
    check_rd("rst_rd0", 3'h0, 16'h0000);
    check_rd("rst_rd2", 3'h2, 16'h0000);
    check_rd("rst_rd4", 3'h4, 16'h0000);
    #2 reset = 1'b0;

    // ---- first stable update exactly 7 edges after release ----
    step(6);
    check_rd("rel_6cyc", 3'h0, 16'h0000);
    step(1);
    check_rd("rel_7cyc", 3'h0, 16'hFFFF);
    check_rd("rel_flag", 3'h4, 16'h0001);

    // ---- table: LED writes, read mux, read-clear, simultaneous selects ----
    for (int i = 0; i < 11; i++) begin
      led_cs    = vecs[i].led_cs;
      switch_cs = vecs[i].switch_cs;
      io_addr   = vecs[i].addr;
      io_wdata  = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d_rdata", i), {16'h0, io_rdata}, {16'h0, vecs[i].exp_rdata});
      step(1);
      check($sformatf("vec%0d_led", i), {8'h0, led_out}, {8'h0, vecs[i].exp_led});
    end
    led_cs    = 1'b0;
    switch_cs = 1'b0;

    // ---- glitch rejection from a clean zero baseline ----
    sw_raw = 24'h000000;
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    step(10);
    sw_raw = 24'h00000F;
    step(2);
    sw_raw = 24'h000000;
    step(12);
    check_rd("glitch_rd0", 3'h0, 16'h0000);
    check_rd("glitch_flag", 3'h4, 16'h0000);
    sw_raw = 24'h00000F;
    step(6);
    check_rd("hold_6cyc", 3'h0, 16'h0000);
    step(1);
    check_rd("hold_7cyc", 3'h0, 16'h000F);

    // ---- status read-clear across an edge ----
    switch_cs = 1'b1;
    io_addr   = IO_OFF_STATUS;
    #1;
    check("clr_first", {16'h0, io_rdata}, 32'h1);
    step(1);
    check("clr_second", {16'h0, io_rdata}, 32'h0);
    switch_cs = 1'b0;

    // ---- clear and set on the same edge: set wins ----
    sw_raw = 24'h0000F0;
    step(6);
    check_rd("race_pre_rd0", 3'h0, 16'h000F);
    switch_cs = 1'b1;
    io_addr   = IO_OFF_STATUS;
    #1;
    check("race_pre_flag", {16'h0, io_rdata}, 32'h0);
    step(1);
    switch_cs = 1'b0;
    check_rd("race_flag", 3'h4, 16'h0001);
    check_rd("race_rd0", 3'h0, 16'h00F0);

    // ---- high byte read and deselected read ----
    sw_raw = 24'hAB1234;
    step(7);
    check_rd("hi_rd0", 3'h0, 16'h1234);
    check_rd("hi_rd2", 3'h2, 16'h00AB);
    switch_cs = 1'b0;
    io_addr   = 3'h0;
    #1;
    check("hi_nocs", {16'h0, io_rdata}, 32'h0);

    // ---- asynchronous reset during an active count ----
    led_cs   = 1'b1;
    io_addr  = 3'h0;
    io_wdata = 16'hFF00;
    step(1);
    io_addr  = 3'h2;
    io_wdata = 16'h0000;
    step(1);
    led_cs = 1'b0;
    check("ar_led_pre", {8'h0, led_out}, 32'h00FF00);
    sw_raw = 24'h555555;
    step(4);
    #2 reset = 1'b1;
    #1;
    check("ar_led", {8'h0, led_out}, 32'h0);
    check_rd("ar_rd0", 3'h0, 16'h0000);
    check_rd("ar_rd2", 3'h2, 16'h0000);
    check_rd("ar_flag", 3'h4, 16'h0000);
    reset = 1'b0;
    step(6);
    check_rd("ar_6cyc", 3'h0, 16'h0000);
    step(1);
    check_rd("ar_7cyc", 3'h0, 16'h5555);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
